// File: rtl/pio_pkg.sv
// Shared constants for the PIO state-machine core: opcodes, JMP conditions,
// MOV source/operation selectors, SET destinations and the sequencer states.
package pio_pkg;

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SET  = 3'b111;

  localparam logic [2:0] JMP_ALWAYS = 3'b000;
  localparam logic [2:0] JMP_X_ZERO = 3'b001;
  localparam logic [2:0] JMP_X_DEC  = 3'b010;
  localparam logic [2:0] JMP_Y_ZERO = 3'b011;
  localparam logic [2:0] JMP_Y_DEC  = 3'b100;
  localparam logic [2:0] JMP_X_NE_Y = 3'b101;
  localparam logic [2:0] JMP_PIN    = 3'b110;
  localparam logic [2:0] JMP_NEVER  = 3'b111;

  localparam logic [2:0] MOV_DST_X = 3'b001;
  localparam logic [2:0] MOV_DST_Y = 3'b010;

  localparam logic [2:0] MOV_SRC_PINS = 3'b000;
  localparam logic [2:0] MOV_SRC_X    = 3'b001;
  localparam logic [2:0] MOV_SRC_Y    = 3'b010;
  localparam logic [2:0] MOV_SRC_ZERO = 3'b011;

  localparam logic [1:0] MOV_OP_NONE = 2'b00;
  localparam logic [1:0] MOV_OP_INV  = 2'b01;
  localparam logic [1:0] MOV_OP_REV  = 2'b10;

  localparam logic [2:0] SET_DST_PINS = 3'b000;
  localparam logic [2:0] SET_DST_X    = 3'b001;
  localparam logic [2:0] SET_DST_Y    = 3'b010;
  localparam logic [2:0] SET_DST_DIRS = 3'b100;

  typedef enum logic {
    ST_EXEC  = 1'b0,
    ST_DELAY = 1'b1
  } sm_state_e;

  // Out-of-range pin indices read as low rather than X.
  function automatic logic pin_sel(input logic [31:0] pins, input logic [31:0] idx);
    logic bit_s;
    if (idx < 32'd32) begin
      bit_s = pins[idx[4:0]];
    end else begin
      bit_s = 1'b0;
    end
    return bit_s;
  endfunction

endpackage

// File: rtl/pio_sm_core_if.sv
// Instruction fetch, configuration, pin and status signals of one PIO state machine.
interface pio_sm_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PIN_W  = 32
);
  logic              en;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] wrap_top;
  logic [ADDR_W-1:0] wrap_bottom;
  logic [PIN_W-1:0]  pin_in;
  logic [ADDR_W-1:0] jmp_pin;
  logic [ADDR_W-1:0] pc;
  logic [4:0]        set_pins;
  logic [4:0]        set_dirs;
  logic              stall;

  modport master (
    output en, instruction, wrap_top, wrap_bottom, pin_in, jmp_pin,
    input  pc, set_pins, set_dirs, stall
  );

  modport slave (
    input  en, instruction, wrap_top, wrap_bottom, pin_in, jmp_pin,
    output pc, set_pins, set_dirs, stall
  );
endinterface

// File: rtl/pio_pc_ctl.sv
// Program counter: jump load takes priority over wrap, otherwise sequential increment.
module pio_pc_ctl
  import pio_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] wrap_top,
  input  logic [ADDR_W-1:0] wrap_bottom,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};

  logic [ADDR_W-1:0] pc_r;

  // Program counter update on each completed instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= PC_ZERO;
    end else if (advance) begin
      if (jump) begin
        pc_r <= jump_addr;
      end else if (pc_r == wrap_top) begin
        pc_r <= wrap_bottom;
      end else begin
        pc_r <= pc_r + PC_ONE;
      end
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/pio_sm_core.sv
// Single PIO state machine: executes JMP/WAIT/MOV/SET with per-instruction
// delay, scratch registers X/Y, and program wrap.
module pio_sm_core
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PIN_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  pio_sm_core_if.slave     bus
);

  localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] D_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  sm_state_e         state_r;
  logic [4:0]        delay_cnt_r;
  logic [DATA_W-1:0] x_r;
  logic [DATA_W-1:0] y_r;
  logic [4:0]        set_pins_r;
  logic [4:0]        set_dirs_r;
  logic              stall_r;

  logic [2:0]        opcode_s;
  logic [4:0]        delay_s;
  logic [2:0]        dest_s;
  logic [4:0]        data_s;
  logic [31:0]       pins_ext_s;
  logic [31:0]       data_w32_s;
  logic [DATA_W-1:0] data_ext_s;
  logic [ADDR_W-1:0] jump_addr_s;
  logic              complete_s;
  logic              jump_s;
  logic              advance_s;
  logic [DATA_W-1:0] x_next_s;
  logic [DATA_W-1:0] y_next_s;
  logic [4:0]        pins_next_s;
  logic [4:0]        dirs_next_s;
  logic [DATA_W-1:0] mov_src_s;
  logic [DATA_W-1:0] mov_rev_s;
  logic [DATA_W-1:0] mov_val_s;
  logic [ADDR_W-1:0] pc_s;

  assign opcode_s    = bus.instruction[15:13];
  assign delay_s     = bus.instruction[12:8];
  assign dest_s      = bus.instruction[7:5];
  assign data_s      = bus.instruction[4:0];
  assign data_w32_s  = {27'd0, data_s};
  assign jump_addr_s = data_w32_s[ADDR_W-1:0];

  // Widen the pin bus and the immediate field to fixed working widths
  always_comb begin
    pins_ext_s = 32'd0;
    pins_ext_s[PIN_W-1:0] = bus.pin_in;
    data_ext_s = D_ZERO;
    data_ext_s[4:0] = data_s;
  end

  // Instruction decode and next-value computation for the scratch/output registers
  always_comb begin
    complete_s  = 1'b1;
    jump_s      = 1'b0;
    x_next_s    = x_r;
    y_next_s    = y_r;
    pins_next_s = set_pins_r;
    dirs_next_s = set_dirs_r;
    mov_src_s   = D_ZERO;
    mov_rev_s   = D_ZERO;
    mov_val_s   = D_ZERO;
    case (opcode_s)
      OP_JMP: begin
        case (dest_s)
          JMP_ALWAYS: jump_s = 1'b1;
          JMP_X_ZERO: jump_s = (x_r == D_ZERO);
          JMP_X_DEC: begin
            jump_s   = (x_r != D_ZERO);
            x_next_s = x_r - D_ONE;
          end
          JMP_Y_ZERO: jump_s = (y_r == D_ZERO);
          JMP_Y_DEC: begin
            jump_s   = (y_r != D_ZERO);
            y_next_s = y_r - D_ONE;
          end
          JMP_X_NE_Y: jump_s = (x_r != y_r);
          JMP_PIN:    jump_s = pin_sel(pins_ext_s, 32'(bus.jmp_pin));
          JMP_NEVER:  jump_s = 1'b0;
          default:    jump_s = 1'b0;
        endcase
      end
      OP_WAIT: begin
        complete_s = (pin_sel(pins_ext_s, data_w32_s) == bus.instruction[7]);
      end
      OP_MOV: begin
        case (bus.instruction[2:0])
          MOV_SRC_PINS: mov_src_s = pins_ext_s[DATA_W-1:0];
          MOV_SRC_X:    mov_src_s = x_r;
          MOV_SRC_Y:    mov_src_s = y_r;
          MOV_SRC_ZERO: mov_src_s = D_ZERO;
          default:      mov_src_s = D_ZERO;
        endcase
        for (int i = 0; i < DATA_W; i++) begin
          mov_rev_s[i] = mov_src_s[DATA_W-1-i];
        end
        case (bus.instruction[4:3])
          MOV_OP_INV: mov_val_s = ~mov_src_s;
          MOV_OP_REV: mov_val_s = mov_rev_s;
          default:    mov_val_s = mov_src_s;
        endcase
        case (dest_s)
          MOV_DST_X: x_next_s = mov_val_s;
          MOV_DST_Y: y_next_s = mov_val_s;
          default:   ;
        endcase
      end
      OP_SET: begin
        case (dest_s)
          SET_DST_PINS: pins_next_s = data_s;
          SET_DST_X:    x_next_s    = data_ext_s;
          SET_DST_Y:    y_next_s    = data_ext_s;
          SET_DST_DIRS: dirs_next_s = data_s;
          default:      ;
        endcase
      end
      default: ;
    endcase
  end

  assign advance_s = bus.en && (state_r == ST_EXEC) && complete_s;

  pio_pc_ctl #(.ADDR_W(ADDR_W)) u_pc_ctl (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance_s),
    .jump        (jump_s),
    .jump_addr   (jump_addr_s),
    .wrap_top    (bus.wrap_top),
    .wrap_bottom (bus.wrap_bottom),
    .pc          (pc_s)
  );

  // Sequencer: commit the executed instruction, then count out its delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EXEC;
      delay_cnt_r <= 5'd0;
      x_r         <= D_ZERO;
      y_r         <= D_ZERO;
      set_pins_r  <= 5'd0;
      set_dirs_r  <= 5'd0;
      stall_r     <= 1'b0;
    end else if (bus.en) begin
      case (state_r)
        ST_EXEC: begin
          if (complete_s) begin
            x_r        <= x_next_s;
            y_r        <= y_next_s;
            set_pins_r <= pins_next_s;
            set_dirs_r <= dirs_next_s;
            if (delay_s != 5'd0) begin
              state_r     <= ST_DELAY;
              delay_cnt_r <= delay_s;
              stall_r     <= 1'b1;
            end else begin
              stall_r <= 1'b0;
            end
          end else begin
            stall_r <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (delay_cnt_r <= 5'd1) begin
            state_r     <= ST_EXEC;
            delay_cnt_r <= 5'd0;
            stall_r     <= 1'b0;
          end else begin
            delay_cnt_r <= delay_cnt_r - 5'd1;
          end
        end
        default: begin
          state_r     <= ST_EXEC;
          delay_cnt_r <= 5'd0;
          stall_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_s;
  assign bus.set_pins = set_pins_r;
  assign bus.set_dirs = set_dirs_r;
  assign bus.stall    = stall_r;

endmodule

// File: tb/tb_pio_sm_core.sv
// Scoreboard bench for pio_sm_core: each scenario loads a program, queues the
// expected pc/stall trace, then drains the queue one clock at a time.
module tb_pio_sm_core;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PIN_W  = 32;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] imem [32];
  exp_t sb [$];
  int pass_cnt = 0;
  int total_cnt = 0;

  pio_sm_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIN_W(PIN_W)) bus ();

  pio_sm_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIN_W(PIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.instruction = imem[bus.pc];

  task automatic load_nops();
    for (int i = 0; i < 32; i++) imem[i] = 16'h4000;
  endtask

  task automatic push(input logic [ADDR_W-1:0] pc, input logic stall);
    exp_t e;
    e.pc = pc;
    e.stall = stall;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total_cnt += 4;
    if (bus.pc !== 5'd0) $display("FAIL reset_pc: got %0d want 0", bus.pc); else pass_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", bus.stall); else pass_cnt++;
    if (dut.x_r !== 32'd0 || dut.y_r !== 32'd0)
      $display("FAIL reset_xy: got x=%h y=%h want 0", dut.x_r, dut.y_r); else pass_cnt++;
    if (bus.set_pins !== 5'd0 || bus.set_dirs !== 5'd0)
      $display("FAIL reset_outs: got pins=%h dirs=%h want 0", bus.set_pins, bus.set_dirs); else pass_cnt++;
  endtask

  task automatic test_jmp_xdec();
    exp_t e;
    load_nops();
    imem[0] = 16'hE023;   // SET X 3
    imem[1] = 16'h0041;   // JMP X-- 1
    do_reset();
    for (int i = 0; i < 4; i++) push(5'd1, 1'b0);
    push(5'd2, 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL jmp_xdec: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    total_cnt++;
    if (dut.x_r !== 32'hFFFF_FFFF) $display("FAIL jmp_xdec_x: got %h want ffffffff", dut.x_r); else pass_cnt++;
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [ADDR_W-1:0] seq [7];
    seq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd2, 5'd3, 5'd4};
    load_nops();
    bus.wrap_top = 5'd4;
    bus.wrap_bottom = 5'd2;
    do_reset();
    total_cnt++;
    if (bus.pc !== 5'd0) $display("FAIL wrap_start: got %0d want 0", bus.pc); else pass_cnt++;
    for (int i = 0; i < 7; i++) push(seq[i], 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL wrap: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    bus.wrap_top = 5'd31;
    bus.wrap_bottom = 5'd0;
  endtask

  task automatic test_delay();
    exp_t e;
    load_nops();
    imem[0] = 16'hE345;   // SET Y 5 [3]
    do_reset();
    push(5'd1, 1'b1); push(5'd1, 1'b1); push(5'd1, 1'b1);
    push(5'd1, 1'b0); push(5'd2, 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL delay: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    total_cnt++;
    if (dut.y_r !== 32'd5) $display("FAIL delay_y: got %h want 5", dut.y_r); else pass_cnt++;
  endtask

  task automatic test_wait();
    exp_t e;
    load_nops();
    imem[0] = 16'h2087;   // WAIT 1 pin 7
    bus.pin_in = 32'd0;
    do_reset();
    for (int i = 0; i < 4; i++) push(5'd0, 1'b1);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL wait_hold: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    bus.pin_in[7] = 1'b1;
    push(5'd1, 1'b0);
    push(5'd2, 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL wait_release: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    bus.pin_in = 32'd0;
  endtask

  task automatic test_mov_rev();
    exp_t e;
    load_nops();
    imem[0] = 16'hE033;   // SET X 0x13
    imem[1] = 16'hA051;   // MOV Y, ::X
    imem[2] = 16'h00A5;   // JMP X!=Y 5
    do_reset();
    push(5'd1, 1'b0); push(5'd2, 1'b0); push(5'd5, 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL mov_rev: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    total_cnt += 2;
    if (dut.y_r !== 32'hC800_0000) $display("FAIL mov_rev_y: got %h want c8000000", dut.y_r); else pass_cnt++;
    if (dut.x_r !== 32'h0000_0013) $display("FAIL mov_rev_x: got %h want 00000013", dut.x_r); else pass_cnt++;
  endtask

  task automatic test_set_pin_en();
    exp_t e;
    load_nops();
    imem[0] = 16'hE015;   // SET PINS 0x15
    imem[1] = 16'hE08A;   // SET PINDIRS 0x0A
    imem[2] = 16'hA02B;   // MOV X, ~NULL
    imem[3] = 16'h00D0;   // JMP PIN 16
    bus.jmp_pin = 5'd3;
    bus.pin_in = 32'h0000_0008;
    do_reset();
    push(5'd1, 1'b0); push(5'd2, 1'b0); push(5'd3, 1'b0); push(5'd16, 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL set_pin: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    total_cnt += 3;
    if (bus.set_pins !== 5'h15) $display("FAIL set_pins: got %h want 15", bus.set_pins); else pass_cnt++;
    if (bus.set_dirs !== 5'h0A) $display("FAIL set_dirs: got %h want 0a", bus.set_dirs); else pass_cnt++;
    if (dut.x_r !== 32'hFFFF_FFFF) $display("FAIL mov_inv_x: got %h want ffffffff", dut.x_r); else pass_cnt++;
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) push(5'd16, 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL en_freeze: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    bus.en = 1'b1;
    push(5'd17, 1'b0);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL en_resume: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    bus.pin_in = 32'd0;
    bus.jmp_pin = 5'd0;
  endtask

  task automatic test_reset_mid_delay();
    exp_t e;
    load_nops();
    imem[0] = 16'hE021;   // SET X 1
    imem[1] = 16'hE342;   // SET Y 2 [3]
    do_reset();
    push(5'd1, 1'b0); push(5'd2, 1'b1); push(5'd2, 1'b1);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL pre_reset: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    rst = 1'b1;
    #1;
    total_cnt += 3;
    if (bus.pc !== 5'd0) $display("FAIL async_rst_pc: got %0d want 0", bus.pc); else pass_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL async_rst_stall: got %0b want 0", bus.stall); else pass_cnt++;
    if (dut.x_r !== 32'd0 || dut.y_r !== 32'd0)
      $display("FAIL async_rst_xy: got x=%h y=%h want 0", dut.x_r, dut.y_r); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    push(5'd1, 1'b0); push(5'd2, 1'b1);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total_cnt++;
      if (bus.pc !== e.pc || bus.stall !== e.stall)
        $display("FAIL post_reset: pc=%0d stall=%0b want pc=%0d stall=%0b", bus.pc, bus.stall, e.pc, e.stall);
      else pass_cnt++;
    end
    total_cnt++;
    if (dut.x_r !== 32'd1) $display("FAIL post_reset_x: got %h want 1", dut.x_r); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b1;
    bus.wrap_top = 5'd31;
    bus.wrap_bottom = 5'd0;
    bus.pin_in = 32'd0;
    bus.jmp_pin = 5'd0;
    load_nops();
    #1;
    test_reset();
    test_jmp_xdec();
    test_wrap();
    test_delay();
    test_wait();
    test_mov_rev();
    test_set_pin_en();
    test_reset_mid_delay();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pio_sm_core.md
PIO_SM_CORE -- requirements
Module: pio_sm_core

Interface
REQ-001 Parameter DATA_W, default 32: scratch register and MOV data width; legal range 8..32.
REQ-002 Parameter ADDR_W, default 5: program counter width; instruction memory depth is 2**ADDR_W.
REQ-003 Parameter PIN_W, default 32: input pin bus width; legal range 1..32.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  state machine enable; 0 freezes all state.
REQ-007 instruction  in  16  instruction word read from memory at address pc.
REQ-008 wrap_top  in  ADDR_W  address of the last instruction before wrap.
REQ-009 wrap_bottom  in  ADDR_W  address that wrap jumps to.
REQ-010 pin_in  in  PIN_W  input pin levels, already synchronised.
REQ-011 jmp_pin  in  ADDR_W  pin index tested by JMP PIN.
REQ-012 pc  out  ADDR_W  current instruction address.
REQ-013 set_pins  out  5  last SET PINS value.
REQ-014 set_dirs  out  5  last SET PINDIRS value.
REQ-015 stall  out  1  high while WAIT is unsatisfied or a delay is counting.

Function
REQ-016 Field decode: opcode [15:13]; delay [12:8]; dest/cond [7:5]; data/addr [4:0].
REQ-017 States: EXEC and DELAY; when en=1, each EXEC cycle executes exactly one instruction.
REQ-018 Next pc when no jump is taken: wrap_bottom if pc==wrap_top, otherwise pc+1 modulo 2**ADDR_W.
REQ-019 JMP (000) conditions:
- 000: always.
- 001: X==0.
- 010: X!=0; X decrements on every execution, with wrap from 0 to all-ones.
- 011: Y==0.
- 100: Y!=0; Y decrements on every execution.
- 101: X!=Y.
- 110: pin_in[jmp_pin]==1.
- 111: never.
REQ-020 A taken jump loads pc with [ADDR_W-1:0] of the data field and takes priority over wrap.
REQ-021 WAIT (001): completes when pin_in[[4:0]]==[7]; otherwise pc holds, stall=1, and the instruction re-executes the next cycle.
REQ-022 MOV (101): destination [7:5] (001 X, 010 Y, other no-op).
- Source [2:0]: 000 pin_in zero-extended, 001 X, 010 Y, 011 zero, other zero.
- Operation [4:3]: 00 none, 01 bitwise invert, 10 bit-reverse across DATA_W, 11 none.
REQ-023 SET (111): destination [7:5] (000 set_pins, 001 X, 010 Y, 100 set_dirs, other no-op).
- X and Y take the data field zero-extended to DATA_W.
REQ-024 Opcodes 010, 011, 100 and 110 are no-ops that advance pc.
REQ-025 Delay handling:
- An instruction that completes with delay D>0 enters DELAY for exactly D further cycles; stall=1 throughout, pc already updated.
- After the last delay cycle, the state returns to EXEC.
- An unsatisfied WAIT does not start its delay.
REQ-026 en=0 holds pc, X, Y, the delay count, state and outputs unchanged; stall holds its value.
REQ-027 JMP X-- with X==0 does not jump and leaves X all-ones; X==1 jumps and leaves X==0.
REQ-028 If wrap_top==pc and a JMP is taken, pc follows the jump target.

Reset
REQ-029 rst asserted drives pc=0, X=0, Y=0, set_pins=0, set_dirs=0, stall=0, state=EXEC and delay count=0 immediately, including mid-delay or mid-wait.
REQ-030 On the first rising edge after rst deasserts, the instruction at address 0 executes.

Structure
REQ-031 A shared package pio_pkg holds the opcode, JMP-condition, MOV source/op and SET destination constants, plus the state enumeration.
REQ-032 The sub-module pio_pc_ctl holds pc, the wrap logic and the jump load; pio_sm_core instantiates it once.

Verification
REQ-033 SET X 3; loop of JMP X-- to self (addr 1); wrap 0..31 -> pc stays at 1 for 4 executions, then 2; X=0xFFFFFFFF.
REQ-034 wrap_top=4, wrap_bottom=2, all no-ops -> pc sequence 0,1,2,3,4,2,3,4.
REQ-035 SET Y 5 with delay 3 at pc 0 -> stall high for 3 cycles; pc=1 during stall; Y=5.
REQ-036 WAIT 1 on pin 7, with pin_in[7] rising 4 cycles later -> pc held for 4 cycles, stall=1, then advances.
REQ-037 SET X 0x13; MOV Y bit-reverse X (DATA_W=32) -> Y=0xC8000000; then JMP X!=Y is taken.
REQ-038 rst asserted during DELAY with count 2 -> pc=0, stall=0, X=Y=0 at once; normal execution from 0 after release.
